// File: rtl/vga_timing_pkg.sv
// Shared raster timing types and default 640x480@60 constants for the VGA
// timing generator and its per-axis counters.
package vga_timing_pkg;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 10;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// count/phase present the lookahead value the coming edge loads.
module vga_axis_counter #(
  parameter int ACTIVE = vga_timing_pkg::DEF_H_ACTIVE,
  parameter int FP     = vga_timing_pkg::DEF_H_FP,
  parameter int SYNC   = vga_timing_pkg::DEF_H_SYNC,
  parameter int BP     = vga_timing_pkg::DEF_H_BP,
  parameter int CW     = vga_timing_pkg::DEF_CW
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   step,
  output logic [CW-1:0]          count,
  output vga_timing_pkg::phase_t phase,
  output logic                   wrap
);

  localparam int TOTAL = vga_timing_pkg::axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] END_ACTIVE = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] END_FRONT  = CW'(ACTIVE + FP - 1);
  localparam logic [CW-1:0] END_SYNC   = CW'(ACTIVE + FP + SYNC - 1);
  localparam logic [CW-1:0] END_TOTAL  = CW'(TOTAL - 1);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_widths
    $error("vga_axis_counter: every region width must be at least 1");
  end
  if (TOTAL >= (1 << CW)) begin : g_bad_cw
    $error("vga_axis_counter: CW too narrow for the axis total");
  end

  logic [CW-1:0]          count_reg, count_next;
  vga_timing_pkg::phase_t phase_reg, phase_next;

  always_comb begin
    wrap       = step && (count_reg == END_TOTAL);
    count_next = count_reg;
    phase_next = phase_reg;
    if (step) begin
      count_next = wrap ? '0 : count_reg + 1'b1;
      unique case (phase_reg)
        vga_timing_pkg::ACTIVE: if (count_reg == END_ACTIVE) phase_next = vga_timing_pkg::FRONT;
        vga_timing_pkg::FRONT:  if (count_reg == END_FRONT)  phase_next = vga_timing_pkg::SYNC;
        vga_timing_pkg::SYNC:   if (count_reg == END_SYNC)   phase_next = vga_timing_pkg::BACK;
        vga_timing_pkg::BACK:   if (wrap)                    phase_next = vga_timing_pkg::ACTIVE;
        default:                                             phase_next = vga_timing_pkg::ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      phase_reg <= vga_timing_pkg::ACTIVE;
    end else begin
      count_reg <= count_next;
      phase_reg <= phase_next;
    end
  end

  assign count = count_next;
  assign phase = phase_next;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: two chained axis counters feeding registered
// coordinates, sync, data-enable and line/frame pulses with zero skew.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 0,
  parameter int CW       = DEF_CW
) (
  input  logic          clk_in,
  input  logic          reset,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic          pre_frame_reg;
  logic          h_step, h_wrap, v_wrap;
  logic [CW-1:0] h_count, v_count;
  phase_t        h_phase, v_phase;

  logic          hsync_reg, vsync_reg, de_reg, line_start_reg, frame_start_reg;
  logic [CW-1:0] pixel_x_reg, pixel_y_reg;

  // The first edge after reset only presents (0,0); counting starts after it.
  assign h_step = !pre_frame_reg;

  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)) u_h_axis (
    .clk_in (clk_in),
    .reset  (reset),
    .step   (h_step),
    .count  (h_count),
    .phase  (h_phase),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)) u_v_axis (
    .clk_in (clk_in),
    .reset  (reset),
    .step   (h_wrap),
    .count  (v_count),
    .phase  (v_phase),
    .wrap   (v_wrap)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pre_frame_reg   <= 1'b1;
      pixel_x_reg     <= '0;
      pixel_y_reg     <= '0;
      de_reg          <= 1'b0;
      hsync_reg       <= ~SYNC_ON;
      vsync_reg       <= ~SYNC_ON;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      pre_frame_reg   <= 1'b0;
      pixel_x_reg     <= h_count;
      pixel_y_reg     <= v_count;
      de_reg          <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
      hsync_reg       <= (h_phase == SYNC) ? SYNC_ON : ~SYNC_ON;
      vsync_reg       <= (v_phase == SYNC) ? SYNC_ON : ~SYNC_ON;
      // Position 0 is reached only by a wrap or by the pre-frame edge.
      line_start_reg  <= pre_frame_reg || h_wrap;
      frame_start_reg <= pre_frame_reg || v_wrap;
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign pixel_x     = pixel_x_reg;
  assign pixel_y     = pixel_y_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, mid-size and tiny active-high timings
// checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       ls;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } vout_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int   n      = -1;
  int   errors = 0;
  int   checks = 0;

  logic       d_hsync, d_vsync, d_de, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       m_hsync, m_vsync, m_de, m_ls, m_fs;
  logic [9:0] m_x, m_y;
  logic       s_hsync, s_vsync, s_de, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  always #5 clk_in = ~clk_in;

  vga_timing_gen dut_d (
    .clk_in(clk_in), .reset(reset), .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
    .pixel_x(d_x), .pixel_y(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2)) dut_m (
    .clk_in(clk_in), .reset(reset), .hsync(m_hsync), .vsync(m_vsync), .de(m_de),
    .pixel_x(m_x), .pixel_y(m_y), .line_start(m_ls), .frame_start(m_fs)
  );

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)) dut_s (
    .clk_in(clk_in), .reset(reset), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
    .pixel_x(s_x), .pixel_y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  // Raster model: k-th edge since release maps to position k mod frame size.
  function automatic vout_t model(input int k, input int ha, input int hf, input int hs, input int hb,
                                  input int va, input int vf, input int vs, input int vb, input int pol);
    vout_t r;
    int ht, vt, p, x, y;
    logic on;
    on = (pol != 0);
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    r  = '0;
    r.hsync = ~on;
    r.vsync = ~on;
    if (k >= 0) begin
      p = k % (ht * vt);
      x = p % ht;
      y = p / ht;
      r.x     = 10'(x);
      r.y     = 10'(y);
      r.de    = (x < ha) && (y < va);
      r.hsync = (x >= ha + hf && x < ha + hf + hs) ? on : ~on;
      r.vsync = (y >= va + vf && y < va + vf + vs) ? on : ~on;
      r.ls    = (x == 0);
      r.fs    = (x == 0) && (y == 0);
    end
    return r;
  endfunction

  function automatic vout_t exp_d(); return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 0); endfunction
  function automatic vout_t exp_m(); return model(n, 16, 2, 4, 2, 480, 10, 2, 33, 0);     endfunction
  function automatic vout_t exp_s(); return model(n, 4, 1, 2, 1, 3, 1, 1, 1, 1);          endfunction

  function automatic vout_t obs_d(); return '{d_hsync, d_vsync, d_de, d_ls, d_fs, d_x, d_y}; endfunction
  function automatic vout_t obs_m(); return '{m_hsync, m_vsync, m_de, m_ls, m_fs, m_x, m_y}; endfunction
  function automatic vout_t obs_s(); return '{s_hsync, s_vsync, s_de, s_ls, s_fs, s_x, s_y}; endfunction

  function automatic phase_t phase_of(input int c, input int a, input int f, input int s);
    if (c < a)         return ACTIVE;
    if (c < a + f)     return FRONT;
    if (c < a + f + s) return SYNC;
    return BACK;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (reset) n++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    n = -1;
    repeat (3) begin
      tick();
      checks++;
      if (obs_d() !== exp_d()) begin errors++; $display("FAIL reset_d got=%h exp=%h", obs_d(), exp_d()); end
      checks++;
      if (obs_s() !== exp_s()) begin errors++; $display("FAIL reset_s got=%h exp=%h", obs_s(), exp_s()); end
    end
    checks++;
    if ({d_hsync, d_vsync, d_de, d_ls, d_fs} !== 5'b11000) begin
      errors++; $display("FAIL reset_flags got=%b exp=11000", {d_hsync, d_vsync, d_de, d_ls, d_fs});
    end
    @(negedge clk_in);
    reset = 1'b1;
    tick();
    checks++;
    if ({d_x, d_y, d_de, d_ls, d_fs, d_hsync, d_vsync} !== {10'd0, 10'd0, 5'b11111}) begin
      errors++; $display("FAIL first_edge x=%0d y=%0d de/ls/fs/hs/vs=%b exp 0 0 11111",
                         d_x, d_y, {d_de, d_ls, d_fs, d_hsync, d_vsync});
    end
    checks++;
    if (obs_m() !== exp_m()) begin errors++; $display("FAIL first_edge_m got=%h exp=%h", obs_m(), exp_m()); end
    checks++;
    if (obs_s() !== exp_s()) begin errors++; $display("FAIL first_edge_s got=%h exp=%h", obs_s(), exp_s()); end
    $display("test_reset done n=%0d", n);
  endtask

  task automatic test_line();
    int hs_cnt = 0;
    int first_hs = -1;
    int de_fall = -1;
    for (int i = 0; i < 800; i++) begin
      tick();
      checks++;
      if (obs_d() !== exp_d()) begin errors++; $display("FAIL line_d n=%0d got=%h exp=%h", n, obs_d(), exp_d()); end
      if (i < 799 && !d_hsync) begin hs_cnt++; if (first_hs < 0) first_hs = int'(d_x); end
      if (!d_de && de_fall < 0) de_fall = int'(d_x);
    end
    checks++;
    if (hs_cnt != 96) begin errors++; $display("FAIL hsync_width got=%0d exp=96", hs_cnt); end
    checks++;
    if (first_hs != 656) begin errors++; $display("FAIL hsync_start got=%0d exp=656", first_hs); end
    checks++;
    if (de_fall != 640) begin errors++; $display("FAIL de_fall got=%0d exp=640", de_fall); end
    checks++;
    if ({d_x, d_y, d_ls} !== {10'd0, 10'd1, 1'b1}) begin
      errors++; $display("FAIL line_wrap x=%0d y=%0d ls=%b exp 0 1 1", d_x, d_y, d_ls);
    end
    $display("test_line done hsync_cycles=%0d", hs_cnt);
  endtask

  task automatic test_frame();
    bit found = 0;
    int period = 0, vs_cnt = 0, vs_min = 1000, vs_max = -1;
    for (int i = 0; i < 13000 && !found; i++) begin
      tick();
      checks++;
      if (obs_m() !== exp_m()) begin errors++; $display("FAIL frame_m n=%0d got=%h exp=%h", n, obs_m(), exp_m()); end
      if (m_fs) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL frame_sync got=timeout exp=frame_start"); end
    found = 0;
    for (int i = 0; i < 13000 && !found; i++) begin
      tick();
      period++;
      checks++;
      if (obs_m() !== exp_m()) begin errors++; $display("FAIL frame_m n=%0d got=%h exp=%h", n, obs_m(), exp_m()); end
      if (!m_vsync) begin
        vs_cnt++;
        if (int'(m_y) < vs_min) vs_min = int'(m_y);
        if (int'(m_y) > vs_max) vs_max = int'(m_y);
      end
      if (m_fs) found = 1;
    end
    checks++;
    if (period != 12600) begin errors++; $display("FAIL frame_period got=%0d exp=12600", period); end
    checks++;
    if (vs_cnt != 48) begin errors++; $display("FAIL vsync_cycles got=%0d exp=48", vs_cnt); end
    checks++;
    if (vs_min != 490 || vs_max != 491) begin
      errors++; $display("FAIL vsync_rows got=%0d..%0d exp=490..491", vs_min, vs_max);
    end
    checks++;
    if ({m_x, m_y} !== 20'd0) begin errors++; $display("FAIL frame_origin x=%0d y=%0d exp 0 0", m_x, m_y); end
    $display("test_frame done period=%0d vsync_cycles=%0d", period, vs_cnt);
  endtask

  task automatic test_small();
    int last_fs = -1;
    int frames = 0;
    int hs_hi = 0, vs_hi = 0;
    for (int i = 0; i < 200 && frames < 4; i++) begin
      tick();
      checks++;
      if (obs_s() !== exp_s()) begin errors++; $display("FAIL small_s n=%0d got=%h exp=%h", n, obs_s(), exp_s()); end
      if (frames > 0 && s_hsync) hs_hi++;
      if (frames > 0 && s_vsync) vs_hi++;
      if (s_fs) begin
        if (last_fs >= 0) begin
          checks++;
          if (n - last_fs != 48) begin errors++; $display("FAIL small_period got=%0d exp=48", n - last_fs); end
        end
        last_fs = n;
        frames++;
      end
    end
    checks++;
    if (frames != 4) begin errors++; $display("FAIL small_frames got=%0d exp=4", frames); end
    // Three full frames observed: 6 lines x 2 hsync pixels and 8 vsync pixels each.
    checks++;
    if (hs_hi != 36 || vs_hi != 24) begin
      errors++; $display("FAIL small_sync_cycles got=%0d/%0d exp=36/24", hs_hi, vs_hi);
    end
    $display("test_small done frames=%0d", frames);
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    for (int i = 0; i < 900 && !found; i++) begin
      tick();
      checks++;
      if (obs_d() !== exp_d()) begin errors++; $display("FAIL pre_reset_d n=%0d got=%h exp=%h", n, obs_d(), exp_d()); end
      if (d_x == 10'd300) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_reset_seek got=timeout exp=x300"); end
    reset = 1'b0;
    n = -1;
    #1;
    checks++;
    if ({d_x, d_y, d_de, d_ls, d_fs, d_hsync, d_vsync} !== {10'd0, 10'd0, 5'b00011}) begin
      errors++; $display("FAIL async_reset x=%0d y=%0d flags=%b exp 0 0 00011",
                         d_x, d_y, {d_de, d_ls, d_fs, d_hsync, d_vsync});
    end
    checks++;
    if (obs_s() !== exp_s()) begin errors++; $display("FAIL async_reset_s got=%h exp=%h", obs_s(), exp_s()); end
    repeat (3) begin
      tick();
      checks++;
      if (obs_m() !== exp_m()) begin errors++; $display("FAIL hold_reset_m got=%h exp=%h", obs_m(), exp_m()); end
    end
    @(negedge clk_in);
    reset = 1'b1;
    tick();
    checks++;
    if ({d_x, d_y, d_fs, d_ls, d_de} !== {10'd0, 10'd0, 3'b111}) begin
      errors++; $display("FAIL restart x=%0d y=%0d fs/ls/de=%b exp 0 0 111", d_x, d_y, {d_fs, d_ls, d_de});
    end
    $display("test_mid_reset done");
  endtask

  task automatic test_random_run();
    for (int seg = 0; seg < 6; seg++) begin
      int len;
      len = int'($urandom_range(200, 2500));
      for (int i = 0; i < len; i++) begin
        tick();
        checks++;
        if (obs_d() !== exp_d()) begin errors++; $display("FAIL rand_d n=%0d got=%h exp=%h", n, obs_d(), exp_d()); end
        checks++;
        if (obs_m() !== exp_m()) begin errors++; $display("FAIL rand_m n=%0d got=%h exp=%h", n, obs_m(), exp_m()); end
        checks++;
        if (obs_s() !== exp_s()) begin errors++; $display("FAIL rand_s n=%0d got=%h exp=%h", n, obs_s(), exp_s()); end
        checks++;
        if ((d_fs && !d_ls) || (s_fs && !s_ls)) begin
          errors++; $display("FAIL fs_implies_ls got d=%b%b s=%b%b exp ls when fs", d_fs, d_ls, s_fs, s_ls);
        end
        checks++;
        if (dut_d.u_h_axis.phase_reg !== phase_of(int'(dut_d.u_h_axis.count_reg), 640, 16, 96) ||
            dut_d.u_v_axis.phase_reg !== phase_of(int'(dut_d.u_v_axis.count_reg), 480, 10, 2)) begin
          errors++; $display("FAIL phase_d got h=%0d@%0d v=%0d@%0d exp range phase",
                             dut_d.u_h_axis.phase_reg, dut_d.u_h_axis.count_reg,
                             dut_d.u_v_axis.phase_reg, dut_d.u_v_axis.count_reg);
        end
        checks++;
        if (dut_s.u_h_axis.phase_reg !== phase_of(int'(dut_s.u_h_axis.count_reg), 4, 1, 2) ||
            dut_s.u_v_axis.phase_reg !== phase_of(int'(dut_s.u_v_axis.count_reg), 3, 1, 1)) begin
          errors++; $display("FAIL phase_s got h=%0d@%0d v=%0d@%0d exp range phase",
                             dut_s.u_h_axis.phase_reg, dut_s.u_h_axis.count_reg,
                             dut_s.u_v_axis.phase_reg, dut_s.u_v_axis.count_reg);
        end
      end
      $display("test_random_run segment=%0d len=%0d n=%0d", seg, len, n);
      if ($urandom_range(0, 1) == 1) begin
        #($urandom_range(1, 3));
        reset = 1'b0;
        n = -1;
        repeat (int'($urandom_range(1, 4))) tick();
        @(negedge clk_in);
        reset = 1'b1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_small();
    test_mid_reset();
    test_random_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
